// File: rtl/axi_sim_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_sim_pkg
// Description : Shared widths and FSM state encoding for the simplified
//               word-addressed AXI4 burst master and its watchdog.
// Contents    : AXI_AW/AXI_DW/AXI_LW/AXI_IDW widths, state_t, is_bus_state()
// Revision    : 1.0 - initial release
// ============================================================================
package axi_sim_pkg;

  localparam int AXI_AW  = 32;  // word address width
  localparam int AXI_DW  = 32;  // data width
  localparam int AXI_LW  = 8;   // burst length (beats-1) width
  localparam int AXI_IDW = 4;   // transaction ID width

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    AR   = 3'd2,
    WDAT = 3'd3,
    RDAT = 3'd4,
    DONE = 3'd5
  } state_t;

  // States in which the master is waiting on a bus handshake.
  function automatic logic is_bus_state(input state_t s);
    return (s == AW) || (s == AR) || (s == WDAT) || (s == RDAT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : axi_watchdog
// Description : Counts consecutive enabled cycles without a kick. expire is
//               asserted combinationally in the TIMEOUT_CYC-th such cycle so
//               the owner can abort on that same clock edge.
// Ports       : clk, rst (async, active-low), enable, kick -> expire
// Revision    : 1.0 - initial release
// ============================================================================
module axi_watchdog #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  localparam logic [TO_W-1:0] c_last_cnt = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] c_cnt_one  = TO_W'(1);

  logic [TO_W-1:0] r_cnt;

  assign expire = enable && !kick && (r_cnt == c_last_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!enable || kick || expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_master
// Description : Single-outstanding burst master. Takes one read or write
//               command from a local client, drives AW/W or AR/R of a slave,
//               passes data through and reports done/ID/LAST/timeout status.
// Ports       : clk, rst (async, active-low)
//               cmd_*            client command channel
//               wdata_*/wstrb_in client write data, rdata_* client read data
//               done, err_*      completion pulse and status
//               WR_ADDR*/WR_DATA*/WR_BACK_ID   slave write channels
//               RD_ADDR*/RD_DATA*/RD_BACK_ID   slave read channels
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_master
  import axi_sim_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_W        = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [AXI_AW-1:0]  cmd_addr,
  input  logic [AXI_LW-1:0]  cmd_len,
  input  logic [AXI_IDW-1:0] cmd_id,
  input  logic [AXI_DW-1:0]  wdata_in,
  input  logic [3:0]         wstrb_in,
  input  logic               wdata_valid,
  output logic               wdata_ready,
  output logic [AXI_DW-1:0]  rdata_out,
  output logic               rdata_valid,
  output logic               rdata_last,
  input  logic               rdata_ready,
  output logic               done,
  output logic               err_timeout,
  output logic               err_last,
  output logic               err_id,
  output logic [AXI_AW-1:0]  WR_ADDR,
  output logic [AXI_LW-1:0]  WR_LEN,
  output logic [AXI_IDW-1:0] WR_ID,
  output logic               WR_ADDR_VALID,
  input  logic               WR_ADDR_READY,
  output logic [AXI_DW-1:0]  WR_DATA,
  output logic [3:0]         WR_STRB,
  output logic               WR_DATA_VALID,
  output logic               WR_DATA_LAST,
  input  logic               WR_DATA_READY,
  input  logic [AXI_IDW-1:0] WR_BACK_ID,
  output logic [AXI_AW-1:0]  RD_ADDR,
  output logic [AXI_LW-1:0]  RD_LEN,
  output logic [AXI_IDW-1:0] RD_ID,
  output logic               RD_ADDR_VALID,
  input  logic               RD_ADDR_READY,
  input  logic [AXI_DW-1:0]  RD_DATA,
  input  logic [AXI_IDW-1:0] RD_BACK_ID,
  input  logic               RD_DATA_LAST,
  input  logic               RD_DATA_VALID,
  output logic               RD_DATA_READY
);

  localparam logic [AXI_LW:0] c_beat_one = (AXI_LW+1)'(1);

  state_t               r_state, w_state_nxt;
  logic                 r_live;        // holds cmd_ready low until first edge after reset
  logic [AXI_AW-1:0]    r_addr;
  logic [AXI_LW-1:0]    r_len;
  logic [AXI_IDW-1:0]   r_id;
  logic                 r_write;
  logic [AXI_LW:0]      r_beat;        // one bit wider than len so 256 beats never wrap
  logic                 r_err_timeout, r_err_last, r_err_id;

  logic w_cmd_hs, w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
  logic w_last, w_kick, w_expire;

  assign w_cmd_hs = (r_state == IDLE) && r_live && cmd_valid;
  assign w_aw_hs  = (r_state == AW)   && WR_ADDR_READY;
  assign w_ar_hs  = (r_state == AR)   && RD_ADDR_READY;
  assign w_w_hs   = (r_state == WDAT) && wdata_valid && WR_DATA_READY;
  assign w_r_hs   = (r_state == RDAT) && RD_DATA_VALID && rdata_ready;
  assign w_last   = (r_beat == {1'b0, r_len});
  assign w_kick   = w_aw_hs || w_ar_hs || w_w_hs || w_r_hs;

  axi_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .enable (is_bus_state(r_state)),
    .kick   (w_kick),
    .expire (w_expire)
  );

  // Address channels present the latched command; the slave owns the
  // address sequence inside the burst.
  assign WR_ADDR = r_addr;
  assign WR_LEN  = r_len;
  assign WR_ID   = r_id;
  assign RD_ADDR = r_addr;
  assign RD_LEN  = r_len;
  assign RD_ID   = r_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    cmd_ready     = 1'b0;
    WR_ADDR_VALID = 1'b0;
    RD_ADDR_VALID = 1'b0;
    WR_DATA       = '0;
    WR_STRB       = '0;
    WR_DATA_VALID = 1'b0;
    WR_DATA_LAST  = 1'b0;
    wdata_ready   = 1'b0;
    rdata_out     = '0;
    rdata_valid   = 1'b0;
    rdata_last    = 1'b0;
    RD_DATA_READY = 1'b0;
    done          = 1'b0;
    err_timeout   = 1'b0;
    err_last      = 1'b0;
    err_id        = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = r_live;
        if (w_cmd_hs) w_state_nxt = cmd_write ? AW : AR;
      end
      AW: begin
        WR_ADDR_VALID = 1'b1;
        if (w_expire)     w_state_nxt = DONE;
        else if (w_aw_hs) w_state_nxt = WDAT;
      end
      AR: begin
        RD_ADDR_VALID = 1'b1;
        if (w_expire)     w_state_nxt = DONE;
        else if (w_ar_hs) w_state_nxt = RDAT;
      end
      WDAT: begin
        WR_DATA_VALID = wdata_valid;
        WR_DATA       = wdata_in;
        WR_STRB       = wstrb_in;
        wdata_ready   = WR_DATA_READY;
        WR_DATA_LAST  = w_last;
        if (w_expire)              w_state_nxt = DONE;
        else if (w_w_hs && w_last) w_state_nxt = DONE;
      end
      RDAT: begin
        rdata_out     = RD_DATA;
        rdata_valid   = RD_DATA_VALID;
        RD_DATA_READY = rdata_ready;
        rdata_last    = w_last;
        // The burst length is ours: RD_DATA_LAST only feeds err_last.
        if (w_expire)              w_state_nxt = DONE;
        else if (w_r_hs && w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        err_timeout = r_err_timeout;
        err_last    = r_err_last;
        // Write ID echo has no per-beat channel, so it is judged here.
        err_id      = r_err_id || (r_write && (WR_BACK_ID != r_id));
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_live        <= 1'b0;
      r_addr        <= '0;
      r_len         <= '0;
      r_id          <= '0;
      r_write       <= 1'b0;
      r_beat        <= '0;
      r_err_timeout <= 1'b0;
      r_err_last    <= 1'b0;
      r_err_id      <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_cmd_hs) begin
        r_addr        <= cmd_addr;
        r_len         <= cmd_len;
        r_id          <= cmd_id;
        r_write       <= cmd_write;
        r_beat        <= '0;
        r_err_timeout <= 1'b0;
        r_err_last    <= 1'b0;
        r_err_id      <= 1'b0;
      end
      if (w_expire) r_err_timeout <= 1'b1;
      if (w_w_hs) r_beat <= r_beat + c_beat_one;
      if (w_r_hs) begin
        r_beat <= r_beat + c_beat_one;
        if (RD_DATA_LAST != w_last) r_err_last <= 1'b1;
        if (RD_BACK_ID != r_id)     r_err_id   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_master
// Description : Self-checking bench for axi_burst_master with a small slave
//               memory and a client-side expectation memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_master;
  import axi_sim_pkg::*;

  localparam int TIMEOUT_CYC = 16;
  localparam int TO_W        = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_id = '0;
  logic [31:0] wdata_in = '0;
  logic [3:0]  wstrb_in = '0;
  logic        wdata_valid = 1'b0, wdata_ready;
  logic [31:0] rdata_out;
  logic        rdata_valid, rdata_last, rdata_ready = 1'b0;
  logic        done, err_timeout, err_last, err_id;
  logic [31:0] WR_ADDR, WR_DATA, RD_ADDR;
  logic [7:0]  WR_LEN, RD_LEN;
  logic [3:0]  WR_ID, RD_ID, WR_STRB;
  logic        WR_ADDR_VALID, WR_DATA_VALID, WR_DATA_LAST, RD_ADDR_VALID, RD_DATA_READY;
  logic        WR_ADDR_READY = 1'b0, WR_DATA_READY = 1'b0, RD_ADDR_READY = 1'b0;
  logic [3:0]  WR_BACK_ID = '0, RD_BACK_ID = '0;
  logic [31:0] RD_DATA = '0;
  logic        RD_DATA_LAST = 1'b0, RD_DATA_VALID = 1'b0;
  logic        any_out;

  always #5 clk = ~clk;

  axi_burst_master #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
    .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .rdata_last(rdata_last), .rdata_ready(rdata_ready),
    .done(done), .err_timeout(err_timeout), .err_last(err_last), .err_id(err_id),
    .WR_ADDR(WR_ADDR), .WR_LEN(WR_LEN), .WR_ID(WR_ID), .WR_ADDR_VALID(WR_ADDR_VALID),
    .WR_ADDR_READY(WR_ADDR_READY), .WR_DATA(WR_DATA), .WR_STRB(WR_STRB),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_LAST(WR_DATA_LAST), .WR_DATA_READY(WR_DATA_READY),
    .WR_BACK_ID(WR_BACK_ID),
    .RD_ADDR(RD_ADDR), .RD_LEN(RD_LEN), .RD_ID(RD_ID), .RD_ADDR_VALID(RD_ADDR_VALID),
    .RD_ADDR_READY(RD_ADDR_READY), .RD_DATA(RD_DATA), .RD_BACK_ID(RD_BACK_ID),
    .RD_DATA_LAST(RD_DATA_LAST), .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
  );

  assign any_out = cmd_ready | wdata_ready | (|rdata_out) | rdata_valid | rdata_last | done |
                   err_timeout | err_last | err_id | (|WR_ADDR) | (|WR_LEN) | (|WR_ID) |
                   WR_ADDR_VALID | (|WR_DATA) | (|WR_STRB) | WR_DATA_VALID | WR_DATA_LAST |
                   (|RD_ADDR) | (|RD_LEN) | (|RD_ID) | RD_ADDR_VALID | RD_DATA_READY;

  int total = 0;
  int bad   = 0;

  // Slave storage (what arrived on WR_DATA) and client expectation (what the
  // client sent), both indexed by word address modulo 256.
  logic [31:0] slave_mem [256];
  logic [31:0] exp_mem   [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    WR_ADDR_READY = 1'b0; WR_DATA_READY = 1'b0; RD_ADDR_READY = 1'b0;
    RD_DATA_VALID = 1'b0; RD_DATA_LAST = 1'b0; RD_DATA = '0;
  endtask

  // One complete burst from command to the cycle after done. slv_last is the
  // beat index on which the slave raises RD_DATA_LAST.
  task automatic run_burst(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input int addr_dly, input logic [3:0] back_id,
                           input int slv_last, input int stall, input logic tgl,
                           input logic exp_last, input logic exp_id, input string tag);
    int cyc, beat, idle, idx;
    logic v, r, hs;
    logic [31:0] d;
    WR_BACK_ID = wr ? back_id : id;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
    #1;
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_id = 4'($urandom);
    // address phase
    cyc = 0; hs = 1'b0;
    while (!hs) begin
      if (wr) WR_ADDR_READY = (cyc >= addr_dly); else RD_ADDR_READY = (cyc >= addr_dly);
      #1;
      check({tag, ".avalid"}, wr ? WR_ADDR_VALID : RD_ADDR_VALID, 1);
      check({tag, ".other_avalid"}, wr ? RD_ADDR_VALID : WR_ADDR_VALID, 0);
      check({tag, ".addr"}, wr ? WR_ADDR : RD_ADDR, addr);
      check({tag, ".len"}, wr ? WR_LEN : RD_LEN, len);
      check({tag, ".id"}, wr ? WR_ID : RD_ID, id);
      hs = (cyc >= addr_dly);
      tick();
      cyc++;
    end
    WR_ADDR_READY = 1'b0; RD_ADDR_READY = 1'b0;
    // data phase
    beat = 0; cyc = 0; idle = 0;
    while (beat <= int'(len) && cyc < 4000) begin
      if (tgl) begin
        v = 1'b1; r = cyc[0];
      end else begin
        v = ($urandom_range(99) >= stall);
        r = ($urandom_range(99) >= stall);
      end
      if (idle >= 8) begin v = 1'b1; r = 1'b1; end
      idx = (int'(addr[7:0]) + beat) & 255;
      d = $urandom;
      if (wr) begin
        wdata_valid = v; wdata_in = d; wstrb_in = 4'($urandom); WR_DATA_READY = r;
        #1;
        check({tag, ".wvalid"}, WR_DATA_VALID, v);
        check({tag, ".wdata_ready"}, wdata_ready, r);
        check({tag, ".wlast"}, WR_DATA_LAST, beat == int'(len));
        check({tag, ".avalid_low"}, WR_ADDR_VALID, 0);
        if (v) begin
          check({tag, ".wdata"}, WR_DATA, d);
          check({tag, ".wstrb"}, WR_STRB, wstrb_in);
        end
        if (v && r) begin
          exp_mem[idx]   = d;
          slave_mem[idx] = WR_DATA;
        end
      end else begin
        RD_DATA_VALID = v; RD_DATA = slave_mem[idx]; RD_DATA_LAST = (beat == slv_last);
        RD_BACK_ID = back_id; rdata_ready = r;
        #1;
        check({tag, ".rvalid"}, rdata_valid, v);
        check({tag, ".rready"}, RD_DATA_READY, r);
        check({tag, ".rlast"}, rdata_last, beat == int'(len));
        check({tag, ".avalid_low"}, RD_ADDR_VALID, 0);
        if (v && r) check({tag, ".rdata"}, rdata_out, exp_mem[idx]);
      end
      check({tag, ".no_early_done"}, done, 0);
      if (v && r) begin beat++; idle = 0; end else idle++;
      tick();
      cyc++;
    end
    idle_inputs();
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".err_timeout"}, err_timeout, 0);
    check({tag, ".err_last"}, err_last, exp_last);
    check({tag, ".err_id"}, err_id, exp_id);
    check({tag, ".ready_in_done"}, cmd_ready, 0);
    tick();
    #1;
    check({tag, ".done_once"}, done, 0);
    check({tag, ".ready_after"}, cmd_ready, 1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    int          addr_dly;
    logic [3:0]  back_id;
    int          slv_last;
    int          stall;
    logic        tgl;
    logic        exp_last;
    logic        exp_id;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n;
    logic wr, ok;
    logic [7:0] len;
    logic [3:0] id, bid;
    int sl;

    vt[0] = '{1'b1, 32'h10, 8'd3,   4'd5, 3, 4'd5, 3,   0,  1'b0, 1'b0, 1'b0}; // write, AW ready late
    vt[1] = '{1'b0, 32'h10, 8'd3,   4'd5, 1, 4'd5, 3,   0,  1'b0, 1'b0, 1'b0}; // read back
    vt[2] = '{1'b0, 32'h12, 8'd0,   4'd2, 0, 4'd2, 0,   0,  1'b1, 1'b0, 1'b0}; // len 0, ready toggles
    vt[3] = '{1'b0, 32'h10, 8'd3,   4'd5, 0, 4'd6, 1,   0,  1'b0, 1'b1, 1'b1}; // early LAST, bad ID
    vt[4] = '{1'b1, 32'h40, 8'd1,   4'd9, 0, 4'd3, 1,   20, 1'b0, 1'b0, 1'b1}; // write ID echo wrong
    vt[5] = '{1'b1, 32'h00, 8'd255, 4'd1, 2, 4'd1, 255, 0,  1'b0, 1'b0, 1'b0}; // 256-beat write
    vt[6] = '{1'b0, 32'h00, 8'd255, 4'd1, 0, 4'd1, 255, 10, 1'b0, 1'b0, 1'b0}; // 256-beat read

    for (int i = 0; i < 256; i++) begin slave_mem[i] = '0; exp_mem[i] = '0; end
    idle_inputs();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset.outs_zero", any_out, 0);
    rst = 1'b1;
    #1;
    check("reset.ready_not_yet", cmd_ready, 0);
    tick();
    check("reset.ready_rises", cmd_ready, 1);
    check("reset.done", done, 0);

    for (int i = 0; i < 7; i++) begin
      run_burst(vt[i].wr, vt[i].addr, vt[i].len, vt[i].id, vt[i].addr_dly, vt[i].back_id,
                vt[i].slv_last, vt[i].stall, vt[i].tgl, vt[i].exp_last, vt[i].exp_id,
                $sformatf("vec%0d", i));
    end

    // watchdog: slave never accepts the write address
    WR_BACK_ID = 4'd3;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_len = 8'd2; cmd_id = 4'd3;
    tick();
    cmd_valid = 1'b0;
    n = 0; ok = 1'b1;
    while (ok && n < 40) begin
      #1;
      if (WR_ADDR_VALID) begin n++; tick(); end else ok = 1'b0;
    end
    check("timeout.valid_cycles", n, TIMEOUT_CYC);
    check("timeout.done", done, 1);
    check("timeout.err_timeout", err_timeout, 1);
    check("timeout.wvalid", WR_DATA_VALID, 0);
    tick();
    #1;
    check("timeout.done_once", done, 0);
    check("timeout.ready_after", cmd_ready, 1);

    // asynchronous reset during beat 2 of an 8-beat write
    WR_BACK_ID = 4'd7;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_len = 8'd7; cmd_id = 4'd7;
    tick();
    cmd_valid = 1'b0; WR_ADDR_READY = 1'b1;
    tick();
    WR_ADDR_READY = 1'b0; wdata_valid = 1'b1; wdata_in = 32'hA5A5_0001; WR_DATA_READY = 1'b1;
    tick();
    wdata_in = 32'hA5A5_0002; WR_DATA_READY = 1'b0;
    #1;
    check("arst.in_beat2", WR_DATA_VALID, 1);
    rst = 1'b0;
    #1;
    check("arst.outs_zero_now", any_out, 0);
    idle_inputs();
    tick();
    check("arst.outs_zero_held", any_out, 0);
    rst = 1'b1;
    #1;
    check("arst.ready_not_yet", cmd_ready, 0);
    tick();
    check("arst.ready_after", cmd_ready, 1);
    run_burst(1'b1, 32'h20, 8'd2, 4'd7, 1, 4'd7, 2, 0, 1'b0, 1'b0, 1'b0, "arst_wr");
    run_burst(1'b0, 32'h20, 8'd2, 4'd7, 0, 4'd7, 2, 0, 1'b0, 1'b0, 1'b0, "arst_rd");

    // randomized bursts; expected errors come from the slave misbehaviour chosen
    for (int i = 0; i < 30; i++) begin
      wr  = 1'($urandom);
      len = 8'($urandom_range(15));
      id  = 4'($urandom);
      bid = ($urandom_range(99) < 20) ? 4'($urandom) : id;
      sl  = ($urandom_range(99) < 20) ? int'($urandom_range(int'(len) + 1)) : int'(len);
      run_burst(wr, 32'($urandom_range(200)), len, id, int'($urandom_range(6)), bid, sl,
                int'($urandom_range(50)), 1'b0, (!wr) && (sl != int'(len)), bid != id,
                $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
